mul_seq: RTL and testbench

Parametrised sequential multiplier for the RISC-V M extension. It implements MUL, MULH, MULHSU and MULHU with a start/busy/done handshake, and retires BITS_PER_CYCLE partial-product bits per clock. A flush input aborts an in-flight multiply on a pipeline redirect. It sits beside the ALU in the execute stage, and the issue logic stalls on busy.

---
 rtl/mul_pkg.sv | 25 ++
 rtl/mul_seq_step.sv | 28 ++
 rtl/mul_seq.sv | 118 +++++++++++
 tb/tb_mul_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential RISC-V M-extension multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN
  } mul_state_e;

  function automatic logic is_signed_a(mul_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  function automatic logic is_signed_b(mul_op_e op);
    return op == OP_MULH;
  endfunction

endpackage

// File: rtl/mul_seq_step.sv
// One shift-add iteration: folds the next multiplier chunk into a right-shifting accumulator.
module mul_seq_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   mplier,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0]   mplier_nxt
);

  localparam int PW = XLEN + BITS_PER_CYCLE;
  localparam int SW = 2*XLEN + BITS_PER_CYCLE;

  logic [PW-1:0] pp;
  logic [SW-1:0] sum;

  // Partial product lands in the top half, then everything shifts down one chunk;
  // after N steps the accumulator holds the full product without a variable shifter.
  always_comb begin
    pp         = {{BITS_PER_CYCLE{1'b0}}, a_mag} * {{XLEN{1'b0}}, mplier[BITS_PER_CYCLE-1:0]};
    sum        = {{BITS_PER_CYCLE{1'b0}}, acc} + {pp, {XLEN{1'b0}}};
    acc_nxt    = sum[SW-1:BITS_PER_CYCLE];
    mplier_nxt = mplier >> BITS_PER_CYCLE;
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential multiplier for MUL/MULH/MULHSU/MULHU with start/busy/done handshake and flush.
module mul_seq
  import mul_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  mul_op_e           op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   result
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  if ((XLEN % 2) != 0 || XLEN < 8) begin : g_bad_xlen
    $error("mul_seq: XLEN must be even and >= 8");
  end
  if (BITS_PER_CYCLE < 1 || (XLEN % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
    $error("mul_seq: BITS_PER_CYCLE must divide XLEN");
  end

  mul_state_e        state, state_nxt;
  logic [CW-1:0]     cnt;
  mul_op_e           op_q;
  logic              neg_q;
  logic [XLEN-1:0]   a_mag_q, mplier_q;
  logic [2*XLEN-1:0] acc_q, acc_nxt, prod_sgn;
  logic [XLEN-1:0]   mplier_nxt, a_mag, b_mag;
  logic              sa, sb, accept, fin;

  mul_seq_step #(
    .XLEN          (XLEN),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .acc       (acc_q),
    .a_mag     (a_mag_q),
    .mplier    (mplier_q),
    .acc_nxt   (acc_nxt),
    .mplier_nxt(mplier_nxt)
  );

  always_comb begin
    sa       = is_signed_a(op) & a[XLEN-1];
    sb       = is_signed_b(op) & b[XLEN-1];
    a_mag    = sa ? -a : a;
    b_mag    = sb ? -b : b;
    prod_sgn = neg_q ? -acc_q : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fin       = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: if (start && !flush) begin
        accept    = 1'b1;
        state_nxt = CALC;
      end
      CALC: begin
        if (flush)                 state_nxt = IDLE;
        else if (cnt == CW'(1))    state_nxt = SIGN;
      end
      SIGN: begin
        state_nxt = IDLE;
        fin       = !flush;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      product  <= '0;
      result   <= '0;
      cnt      <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      a_mag_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      done <= fin;
      if (accept) begin
        op_q     <= op;
        neg_q    <= sa ^ sb;
        a_mag_q  <= a_mag;
        mplier_q <= b_mag;
        acc_q    <= '0;
        cnt      <= CW'(N);
      end else if (state == CALC && !flush) begin
        acc_q    <= acc_nxt;
        mplier_q <= mplier_nxt;
        cnt      <= cnt - CW'(1);
      end
      if (fin) begin
        product <= prod_sgn;
        result  <= (op_q == OP_MUL) ? prod_sgn[XLEN-1:0] : prod_sgn[2*XLEN-1:XLEN];
      end
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed and randomized checks of mul_seq (1 and 4 bits per cycle) against an arithmetic model.
module tb_mul_seq;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic st1 = 1'b0, fl1 = 1'b0;
  mul_op_e op1 = OP_MUL;
  logic [31:0] a1 = '0, b1 = '0;
  logic bz1, dn1;
  logic [63:0] pr1;
  logic [31:0] rs1;

  logic st4 = 1'b0, fl4 = 1'b0;
  mul_op_e op4 = OP_MUL;
  logic [31:0] a4 = '0, b4 = '0;
  logic bz4, dn4;
  logic [63:0] pr4;
  logic [31:0] rs4;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_prod1 = '0;
  logic [31:0] last_res1 = '0;

  always #5 clk = ~clk;

  mul_seq #(.XLEN(32), .BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .flush(fl1), .op(op1), .a(a1), .b(b1),
    .busy(bz1), .done(dn1), .product(pr1), .result(rs1)
  );

  mul_seq #(.XLEN(32), .BITS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .flush(fl4), .op(op4), .a(a4), .b(b4),
    .busy(bz4), .done(dn4), .product(pr4), .result(rs4)
  );

  // Reference: extend each operand per its signedness, multiply, keep 64 bits.
  function automatic logic [63:0] model(mul_op_e op, logic [31:0] a, logic [31:0] b);
    logic [63:0] xa, xb;
    logic sa, sb;
    sa = (op == OP_MULH) || (op == OP_MULHSU);
    sb = (op == OP_MULH);
    xa = {{32{sa & a[31]}}, a};
    xb = {{32{sb & b[31]}}, b};
    return xa * xb;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input bit sel4, input mul_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input int poke, input string tag);
    logic [63:0] ep;
    logic [31:0] er;
    int lat;
    int edges;
    bit seen;
    ep    = model(op, a, b);
    er    = (op == OP_MUL) ? ep[31:0] : ep[63:32];
    lat   = sel4 ? 9 : 33;
    edges = 0;
    seen  = 0;
    if (sel4) begin st4 = 1; op4 = op; a4 = a; b4 = b; end
    else      begin st1 = 1; op1 = op; a1 = a; b1 = b; end
    @(posedge clk); #1;
    if (sel4) st4 = 0; else st1 = 0;
    chk({tag, ".busy_after_accept"}, 64'(sel4 ? bz4 : bz1), 64'd1);
    while (!seen && edges < 100) begin
      @(posedge clk); edges++; #1;
      if (!sel4 && edges == poke) begin
        st1 = 1; op1 = mul_op_e'(2'(op) ^ 2'b11); a1 = ~a; b1 = b ^ 32'h5a5a_a5a5;
      end else if (!sel4 && edges == poke + 1) begin
        st1 = 0;
      end
      seen = sel4 ? dn4 : dn1;
    end
    chk({tag, ".latency"}, 64'(edges), 64'(lat));
    chk({tag, ".product"}, sel4 ? pr4 : pr1, ep);
    chk({tag, ".result"}, 64'(sel4 ? rs4 : rs1), 64'(er));
    chk({tag, ".busy_at_done"}, 64'(sel4 ? bz4 : bz1), 64'd0);
    if (!sel4) begin last_prod1 = ep; last_res1 = er; end
  endtask

  initial begin
    bit saw_done;
    logic [31:0] ra, rb;
    mul_op_e rop;

    #12;
    chk("reset.busy", 64'(bz1), 64'd0);
    chk("reset.done", 64'(dn1), 64'd0);
    chk("reset.product", pr1, 64'd0);
    chk("reset.result", 64'(rs1), 64'd0);
    @(negedge clk) rst_n = 1;
    @(negedge clk);

    run_op(0, OP_MUL, 32'd2, 32'd2, 0, "mul_2x2");
    run_op(0, OP_MUL, 32'd4, 32'd2, 0, "mul_4x2_done_cycle");
    run_op(0, OP_MULH, 32'hFFFF_FFFE, 32'hFFFF_FFF6, 0, "mulh_neg_neg");
    run_op(0, OP_MULHU, 32'hFFFF_FFFE, 32'hFFFF_FFF6, 0, "mulhu_big");
    run_op(0, OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 0, "mulhsu_m1x2");
    run_op(0, OP_MULH, 32'h8000_0000, 32'h8000_0000, 0, "mulh_minmin");
    run_op(0, OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5, "start_while_busy");

    for (int i = 0; i < 12; i++) begin
      rop = mul_op_e'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) rb = 32'hFFFF_FFFF;
      run_op(0, rop, ra, rb, 0, "rand_bpc1");
    end

    // Flush ten cycles into CALC: abort without done, outputs keep previous op.
    @(negedge clk);
    st1 = 1; op1 = OP_MUL; a1 = 32'd7; b1 = 32'd9;
    @(posedge clk); #1 st1 = 0;
    repeat (10) @(posedge clk);
    #1 fl1 = 1;
    @(posedge clk); #1 fl1 = 0;
    chk("flush.busy", 64'(bz1), 64'd0);
    chk("flush.done", 64'(dn1), 64'd0);
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (dn1) saw_done = 1;
    end
    chk("flush.no_done", 64'(saw_done), 64'd0);
    chk("flush.product_kept", pr1, last_prod1);
    chk("flush.result_kept", 64'(rs1), 64'(last_res1));

    // flush together with start in IDLE: start is ignored.
    st1 = 1; fl1 = 1; op1 = OP_MUL; a1 = 32'd3; b1 = 32'd3;
    @(posedge clk); #1 st1 = 0; fl1 = 0;
    chk("flush_start_idle.busy", 64'(bz1), 64'd0);
    @(posedge clk); #1;
    chk("flush_start_idle.busy2", 64'(bz1), 64'd0);

    // Asynchronous reset mid-CALC.
    st1 = 1; op1 = OP_MULHU; a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF;
    @(posedge clk); #1 st1 = 0;
    repeat (10) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst.busy", 64'(bz1), 64'd0);
    chk("arst.done", 64'(dn1), 64'd0);
    chk("arst.product", pr1, 64'd0);
    chk("arst.result", 64'(rs1), 64'd0);
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    run_op(0, OP_MUL, 32'd3, 32'd5, 0, "mul_3x5_after_reset");

    run_op(1, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "bpc4_mulhu");
    run_op(1, OP_MULH, 32'h8000_0000, 32'h7FFF_FFFF, 0, "bpc4_mulh");
    for (int i = 0; i < 6; i++) begin
      rop = mul_op_e'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      run_op(1, rop, ra, rb, 0, "rand_bpc4");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
